axi_wr_burst_scheduler: RTL and testbench

//  Splits one large write job (start address, length in 512b beats) into AXI-legal bursts.

---
 rtl/axi_wr_sched_pkg.sv | 36 +++
 rtl/wr_burst_sizer.sv | 44 ++++
 rtl/axi_wr_burst_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_axi_wr_burst_scheduler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_sched_pkg.sv
// ---------------------------------------------------------------------------
// axi_wr_sched_pkg
//
// Purpose:
//    Shared constants and types for the AXI write burst scheduler: beat and
//    page geometry, the scheduler state encoding and the bit positions of the
//    job_error report.
//
// Contents:
//    BEAT_BYTES / BEAT_SHIFT   : one 512-bit beat is 64 bytes
//    PAGE_BYTES / PAGE_SHIFT   : AXI bursts must not cross a 4 KB page
//    PAGE_BEATS                : beats in one full page
//    state_t                   : IDLE, ISSUE, HOLD, DRAIN, DONE
//    ERR_* indices             : layout of job_error = {spurious_b, bresp[1:0]}
// ---------------------------------------------------------------------------
package axi_wr_sched_pkg;

    localparam int BEAT_BYTES = 64;
    localparam int BEAT_SHIFT = 6;
    localparam int PAGE_BYTES = 4096;
    localparam int PAGE_SHIFT = 12;
    localparam int PAGE_BEATS = PAGE_BYTES / BEAT_BYTES;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int ERR_SPURIOUS_BIT = 2;
    localparam int ERR_RESP_MSB     = 1;
    localparam int ERR_RESP_LSB     = 0;

endpackage

// File: rtl/wr_burst_sizer.sv
// ---------------------------------------------------------------------------
// wr_burst_sizer
//
// Purpose:
//    Combinational size of the next burst: the smallest of the beats still
//    owed to the job, the configured burst cap, and the beats left before the
//    current address reaches the next 4 KB page boundary.
//
// Ports:
//    remaining    in  32  beats of the job not yet issued
//    page_offset  in  6   beat index inside the current page (addr[11:6])
//    beats        out 7   burst length, 1..64 whenever remaining != 0
// ---------------------------------------------------------------------------
module wr_burst_sizer
    import axi_wr_sched_pkg::*;
#(
    parameter int MAX_BURST = 32
) (
    input  logic [31:0] remaining,
    input  logic [5:0]  page_offset,
    output logic [6:0]  beats
);

    localparam logic [6:0] CAP_BEATS  = 7'(MAX_BURST);
    localparam logic [6:0] FULL_PAGE  = 7'(PAGE_BEATS);

    // Page offset 0 leaves a whole page (64 beats), which is why the
    // subtraction is done at 7 bits rather than 6.
    logic [6:0] page_left;
    assign page_left = FULL_PAGE - {1'b0, page_offset};

    // Narrow the candidate in two steps; the remaining-beats compare is done
    // at full 32-bit width so large jobs never alias into a small burst.
    always_comb begin
        beats = page_left;
        if (CAP_BEATS < beats) begin
            beats = CAP_BEATS;
        end
        if (remaining < {25'd0, beats}) begin
            beats = remaining[6:0];
        end
    end

endmodule

// File: rtl/axi_wr_burst_scheduler.sv
// ---------------------------------------------------------------------------
// axi_wr_burst_scheduler
//
// Purpose:
//    Breaks one write job (byte address + length in 512-bit beats) into
//    AXI-legal bursts that never cross a 4 KB page, hands them one at a time
//    to the write master's local command port, limits how many bursts may be
//    waiting for a B response, and reports completion and error status.
//    Write data does not pass through this block.
//
// Ports:
//    clk, rst_n          clock, asynchronous active-low reset
//    clear               synchronous abort back to IDLE
//    job_start           1-cycle start pulse, only honoured in IDLE
//    job_addr            job byte address, low 6 bits ignored
//    job_beats           job length in beats (0 allowed)
//    job_busy            high from the cycle after start through the done pulse
//    job_done            1-cycle completion pulse
//    job_error           {spurious_b, first nonzero bresp}, held until next start
//    lcl_istart          1-cycle burst command pulse to the write master
//    lcl_iaddr           burst byte address, valid with lcl_istart
//    lcl_inum            burst length in beats (1..64), valid with lcl_istart
//    lcl_ibusy           write master busy, blocks new commands
//    m_axi_bvalid        B channel handshake monitor (bready is tied high)
//    m_axi_bresp         B response code
// ---------------------------------------------------------------------------
module axi_wr_burst_scheduler
    import axi_wr_sched_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_BURST       = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,

    input  logic                  job_start,
    input  logic [ADDR_WIDTH-1:0] job_addr,
    input  logic [31:0]           job_beats,
    output logic                  job_busy,
    output logic                  job_done,
    output logic [2:0]            job_error,

    output logic                  lcl_istart,
    output logic [ADDR_WIDTH-1:0] lcl_iaddr,
    output logic [7:0]            lcl_inum,
    input  logic                  lcl_ibusy,

    input  logic                  m_axi_bvalid,
    input  logic [1:0]            m_axi_bresp
);

    localparam int                    STEP_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [3:0]            OUT_LIMIT  = 4'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK  = ADDR_WIDTH'(BEAT_BYTES - 1);

    state_t                  state;
    state_t                  next_state;

    logic [ADDR_WIDTH-1:0]   addr;
    logic [31:0]             remaining;
    logic [3:0]              outstanding;
    logic [6:0]              burst_beats;
    logic [ADDR_WIDTH-1:0]   burst_bytes;

    logic                    fire;
    logic                    start_accept;
    logic                    b_seen;
    logic                    b_counted;
    logic                    b_spurious;

    // Burst length for the command that would be issued this cycle.
    wr_burst_sizer #(
        .MAX_BURST (MAX_BURST)
    ) u_sizer (
        .remaining   (remaining),
        .page_offset (addr[PAGE_SHIFT-1:BEAT_SHIFT]),
        .beats       (burst_beats)
    );

    assign burst_bytes = {{(ADDR_WIDTH-7){1'b0}}, burst_beats} << STEP_SHIFT;

    // A start is only taken in IDLE; a simultaneous clear wins so the abort
    // cannot be overridden by a new job in the same cycle.
    assign start_accept = (state == IDLE) && job_start && !clear;

    // B responses are only meaningful while a job is running; late responses
    // that arrive after a clear land in IDLE and are dropped.  A response with
    // nothing outstanding is flagged rather than allowed to underflow.
    assign b_seen     = m_axi_bvalid && (state != IDLE);
    assign b_counted  = b_seen && (outstanding != 4'd0);
    assign b_spurious = b_seen && (outstanding == 4'd0);

    assign job_busy = (state != IDLE);
    assign job_done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.  ISSUE waits until the master is idle and the
    // outstanding window has room; HOLD is a single dead cycle so the
    // master's registered ibusy has risen before ISSUE looks at it again.
    always_comb begin
        next_state = state;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (start_accept) begin
                    next_state = (job_beats == 32'd0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (!lcl_ibusy && (outstanding < OUT_LIMIT)) begin
                    fire       = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                next_state = (remaining != 32'd0) ? ISSUE : DRAIN;
            end
            DRAIN: begin
                if (outstanding == 4'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (clear) begin
            fire       = 1'b0;
            next_state = IDLE;
        end
    end

    // Address / remaining-beat bookkeeping and the registered command port.
    // Both counters advance in the same cycle the command is registered, so
    // HOLD already sees the post-burst remaining count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            remaining  <= '0;
            lcl_istart <= 1'b0;
            lcl_iaddr  <= '0;
            lcl_inum   <= '0;
        end else if (clear) begin
            addr       <= '0;
            remaining  <= '0;
            lcl_istart <= 1'b0;
            lcl_iaddr  <= '0;
            lcl_inum   <= '0;
        end else begin
            lcl_istart <= fire;
            if (start_accept) begin
                addr      <= job_addr & ~BEAT_MASK;
                remaining <= job_beats;
            end
            if (fire) begin
                lcl_iaddr <= addr;
                lcl_inum  <= {1'b0, burst_beats};
                addr      <= addr + burst_bytes;
                remaining <= remaining - {25'd0, burst_beats};
            end
        end
    end

    // Outstanding-burst counter and error capture.  The counter moves on the
    // visible istart pulse, so a command and a response in the same cycle
    // cancel out.  Only the first nonzero bresp of a job is kept; the
    // spurious-response flag is sticky until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            job_error   <= '0;
        end else if (clear) begin
            outstanding <= '0;
        end else begin
            if (lcl_istart && !b_counted) begin
                outstanding <= outstanding + 4'd1;
            end else if (!lcl_istart && b_counted) begin
                outstanding <= outstanding - 4'd1;
            end

            if (start_accept) begin
                job_error <= '0;
            end else begin
                if (b_spurious) begin
                    job_error[ERR_SPURIOUS_BIT] <= 1'b1;
                end
                if (b_seen && (m_axi_bresp != 2'b00) &&
                    (job_error[ERR_RESP_MSB:ERR_RESP_LSB] == 2'b00)) begin
                    job_error[ERR_RESP_MSB:ERR_RESP_LSB] <= m_axi_bresp;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_scheduler.sv
// Directed bench for axi_wr_burst_scheduler.  The DUT runs with MAX_BURST=32
// and a deliberately small outstanding window of 2 so the back-pressure case
// is reachable with short jobs.  Every cycle is advanced by applyStimulus,
// which samples the DUT on the falling edge, records each command and done
// pulse, and drives the inputs for the next rising edge.
module tb_axi_wr_burst_scheduler;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        job_start;
    logic [63:0] job_addr;
    logic [31:0] job_beats;
    logic        job_busy;
    logic        job_done;
    logic [2:0]  job_error;
    logic        lcl_istart;
    logic [63:0] lcl_iaddr;
    logic [7:0]  lcl_inum;
    logic        lcl_ibusy;
    logic        m_axi_bvalid;
    logic [1:0]  m_axi_bresp;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [63:0] ist_addr_q[$];
    logic [7:0]  ist_num_q[$];
    int          ist_cyc_q[$];
    int          done_cyc_q[$];
    int          b_due_q[$];
    logic [1:0]  b_resp_q[$];

    bit          auto_b;
    logic [1:0]  resp_table [4];
    int          burst_idx;

    bit          pend_start;
    bit          pend_clear;
    bit          pend_b;
    logic [63:0] pend_addr;
    logic [31:0] pend_beats;
    logic [1:0]  pend_resp;

    axi_wr_burst_scheduler #(
        .ADDR_WIDTH      (64),
        .DATA_WIDTH      (512),
        .MAX_BURST       (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .job_start    (job_start),
        .job_addr     (job_addr),
        .job_beats    (job_beats),
        .job_busy     (job_busy),
        .job_done     (job_done),
        .job_error    (job_error),
        .lcl_istart   (lcl_istart),
        .lcl_iaddr    (lcl_iaddr),
        .lcl_inum     (lcl_inum),
        .lcl_ibusy    (lcl_ibusy),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bresp  (m_axi_bresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on mismatch counts the failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle: sample on the falling edge, then drive inputs that
    // the DUT will sample on the next rising edge.  With auto_b set, each
    // command gets a B response two cycles after its istart cycle.
    task automatic applyStimulus();
        @(negedge clk);
        cyc++;
        if (lcl_istart === 1'b1) begin
            ist_addr_q.push_back(lcl_iaddr);
            ist_num_q.push_back(lcl_inum);
            ist_cyc_q.push_back(cyc);
            if (auto_b) begin
                b_due_q.push_back(cyc + 2);
                b_resp_q.push_back(resp_table[burst_idx % 4]);
            end
            burst_idx++;
        end
        if (job_done === 1'b1) begin
            done_cyc_q.push_back(cyc);
        end
        job_start = pend_start;
        job_addr  = pend_addr;
        job_beats = pend_beats;
        clear     = pend_clear;
        if (b_due_q.size() > 0 && b_due_q[0] == cyc) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = b_resp_q[0];
            void'(b_due_q.pop_front());
            void'(b_resp_q.pop_front());
        end else if (pend_b) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = pend_resp;
        end else begin
            m_axi_bvalid = 1'b0;
            m_axi_bresp  = 2'b00;
        end
        pend_start = 1'b0;
        pend_clear = 1'b0;
        pend_b     = 1'b0;
        pend_resp  = 2'b00;
    endtask

    task automatic newTest();
        ist_addr_q.delete();
        ist_num_q.delete();
        ist_cyc_q.delete();
        done_cyc_q.delete();
        b_due_q.delete();
        b_resp_q.delete();
        burst_idx = 0;
    endtask

    task automatic startJob(input logic [63:0] a, input logic [31:0] n, output int s);
        pend_start = 1'b1;
        pend_addr  = a;
        pend_beats = n;
        applyStimulus();
        s = cyc;
    endtask

    // Bounded wait for the next done pulse; a timeout is a failed check.
    task automatic waitDone(input string tag, input int limit);
        int n0;
        n0 = done_cyc_q.size();
        for (int i = 0; i < limit && done_cyc_q.size() == n0; i++) begin
            applyStimulus();
        end
        checkOutput(tag, 64'(done_cyc_q.size() > n0), 64'd1);
    endtask

    task automatic checkBurst(input string tag, input int idx,
                              input logic [63:0] a, input logic [7:0] n);
        checkOutput($sformatf("%s_present", tag), 64'(ist_addr_q.size() > idx), 64'd1);
        if (ist_addr_q.size() > idx) begin
            checkOutput($sformatf("%s_addr", tag), ist_addr_q[idx], a);
            checkOutput($sformatf("%s_num", tag), 64'(ist_num_q[idx]), 64'(n));
        end
    endtask

    task automatic checkDoneAt(input string tag, input int s, input int latency);
        if (done_cyc_q.size() > 0) begin
            checkOutput(tag, 64'(done_cyc_q[0] - s), 64'(latency));
        end
    endtask

    initial begin
        int s;
        int c;

        rst_n        = 1'b0;
        clear        = 1'b0;
        job_start    = 1'b0;
        job_addr     = '0;
        job_beats    = '0;
        lcl_ibusy    = 1'b0;
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        pend_start   = 1'b0;
        pend_clear   = 1'b0;
        pend_b       = 1'b0;
        pend_addr    = '0;
        pend_beats   = '0;
        pend_resp    = 2'b00;
        auto_b       = 1'b0;
        burst_idx    = 0;
        for (int i = 0; i < 4; i++) resp_table[i] = 2'b00;

        // Reset values
        applyStimulus();
        applyStimulus();
        checkOutput("reset_busy", 64'(job_busy), 64'd0);
        checkOutput("reset_done", 64'(job_done), 64'd0);
        checkOutput("reset_error", 64'(job_error), 64'd0);
        checkOutput("reset_istart", 64'(lcl_istart), 64'd0);
        checkOutput("reset_iaddr", lcl_iaddr, 64'd0);
        checkOutput("reset_inum", 64'(lcl_inum), 64'd0);
        rst_n = 1'b1;
        applyStimulus();
        applyStimulus();

        // T1: 100 beats from 0x1000, responses 2 cycles after each command;
        // a second start mid-job must be ignored.
        $display("[TB] T1 basic split");
        newTest();
        auto_b = 1'b1;
        startJob(64'h1000, 32'd100, s);
        applyStimulus();
        checkOutput("t1_busy_after_start", 64'(job_busy), 64'd1);
        repeat (3) applyStimulus();
        pend_start = 1'b1;
        pend_addr  = 64'hF000;
        pend_beats = 32'd5;
        applyStimulus();
        waitDone("t1_done_seen", 40);
        checkOutput("t1_busy_with_done", 64'(job_busy), 64'd1);
        checkOutput("t1_error", 64'(job_error), 64'd0);
        checkDoneAt("t1_done_latency", s, 12);
        applyStimulus();
        checkOutput("t1_busy_after_done", 64'(job_busy), 64'd0);
        repeat (4) applyStimulus();
        checkOutput("t1_burst_count", 64'(ist_addr_q.size()), 64'd4);
        checkOutput("t1_done_count", 64'(done_cyc_q.size()), 64'd1);
        checkBurst("t1_b0", 0, 64'h1000, 8'd32);
        checkBurst("t1_b1", 1, 64'h1800, 8'd32);
        checkBurst("t1_b2", 2, 64'h2000, 8'd32);
        checkBurst("t1_b3", 3, 64'h2800, 8'd4);
        if (ist_cyc_q.size() > 1) begin
            checkOutput("t1_first_istart_cycle", 64'(ist_cyc_q[0] - s), 64'd2);
            checkOutput("t1_istart_gap", 64'(ist_cyc_q[1] - ist_cyc_q[0]), 64'd2);
        end

        // T2: 3 beats straddling the 4 KB boundary.
        $display("[TB] T2 page split");
        newTest();
        startJob(64'h1FC0, 32'd3, s);
        waitDone("t2_done_seen", 30);
        checkDoneAt("t2_done_latency", s, 8);
        checkOutput("t2_burst_count", 64'(ist_addr_q.size()), 64'd2);
        checkBurst("t2_b0", 0, 64'h1FC0, 8'd1);
        checkBurst("t2_b1", 1, 64'h2000, 8'd2);
        repeat (2) applyStimulus();

        // T3: outstanding window of 2 with responses withheld.
        $display("[TB] T3 outstanding limit");
        newTest();
        auto_b = 1'b0;
        startJob(64'h10000, 32'd128, s);
        repeat (10) applyStimulus();
        checkOutput("t3_capped_count", 64'(ist_addr_q.size()), 64'd2);
        pend_b = 1'b1;
        applyStimulus();
        c = cyc;
        applyStimulus();
        checkOutput("t3_no_istart_yet", 64'(ist_addr_q.size()), 64'd2);
        pend_b = 1'b1;
        applyStimulus();
        checkOutput("t3_third_issued", 64'(ist_addr_q.size()), 64'd3);
        repeat (2) applyStimulus();
        checkOutput("t3_fourth_after_overlap", 64'(ist_addr_q.size()), 64'd4);
        if (ist_cyc_q.size() > 3) begin
            checkOutput("t3_third_cycle", 64'(ist_cyc_q[2] - c), 64'd2);
            checkOutput("t3_fourth_cycle", 64'(ist_cyc_q[3] - c), 64'd4);
        end
        checkBurst("t3_b0", 0, 64'h10000, 8'd32);
        checkBurst("t3_b1", 1, 64'h10800, 8'd32);
        checkBurst("t3_b2", 2, 64'h11000, 8'd32);
        checkBurst("t3_b3", 3, 64'h11800, 8'd32);
        pend_b = 1'b1;
        applyStimulus();
        pend_b = 1'b1;
        applyStimulus();
        waitDone("t3_done_seen", 10);
        checkDoneAt("t3_done_latency", c, 8);
        checkOutput("t3_error", 64'(job_error), 64'd0);
        repeat (2) applyStimulus();

        // T4: second response SLVERR, third DECERR; first one sticks.
        $display("[TB] T4 error capture");
        newTest();
        auto_b = 1'b1;
        resp_table[0] = 2'b00;
        resp_table[1] = 2'b10;
        resp_table[2] = 2'b11;
        resp_table[3] = 2'b00;
        startJob(64'h3000, 32'd100, s);
        waitDone("t4_done_seen", 60);
        checkOutput("t4_error_at_done", 64'(job_error), 64'h2);
        repeat (3) applyStimulus();
        checkOutput("t4_error_held", 64'(job_error), 64'h2);
        checkOutput("t4_done_count", 64'(done_cyc_q.size()), 64'd1);
        checkOutput("t4_burst_count", 64'(ist_addr_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) resp_table[i] = 2'b00;

        // T5: zero-length job, then a stray response while IDLE.
        $display("[TB] T5 zero beats");
        newTest();
        startJob(64'h5000, 32'd0, s);
        applyStimulus();
        checkOutput("t5_busy", 64'(job_busy), 64'd1);
        checkOutput("t5_not_done_yet", 64'(job_done), 64'd0);
        checkOutput("t5_error_cleared", 64'(job_error), 64'd0);
        applyStimulus();
        checkOutput("t5_done", 64'(job_done), 64'd1);
        applyStimulus();
        pend_b    = 1'b1;
        pend_resp = 2'b11;
        applyStimulus();
        repeat (2) applyStimulus();
        checkOutput("t5_idle_b_error", 64'(job_error), 64'd0);
        checkOutput("t5_idle_busy", 64'(job_busy), 64'd0);
        checkOutput("t5_no_istart", 64'(ist_addr_q.size()), 64'd0);
        checkOutput("t5_done_count", 64'(done_cyc_q.size()), 64'd1);

        // T5b: response with nothing outstanding during a job.
        newTest();
        startJob(64'h5000, 32'd0, s);
        pend_b = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("t5b_done", 64'(job_done), 64'd1);
        checkOutput("t5b_spurious_error", 64'(job_error), 64'h4);
        repeat (2) applyStimulus();

        // T6: clear after the second command.
        $display("[TB] T6 clear and reset");
        newTest();
        auto_b = 1'b1;
        startJob(64'h8000, 32'd200, s);
        repeat (4) applyStimulus();
        pend_clear = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("t6_busy_after_clear", 64'(job_busy), 64'd0);
        checkOutput("t6_istart_after_clear", 64'(lcl_istart), 64'd0);
        repeat (12) applyStimulus();
        checkOutput("t6_no_done", 64'(done_cyc_q.size()), 64'd0);
        checkOutput("t6_burst_count", 64'(ist_addr_q.size()), 64'd2);

        // A following zero-length job only finishes on time if clear zeroed
        // the outstanding count.
        newTest();
        startJob(64'h6000, 32'd0, s);
        waitDone("t6b_done_seen", 6);
        checkDoneAt("t6b_done_latency", s, 2);
        repeat (2) applyStimulus();

        // Asynchronous reset while a command is on the port.
        newTest();
        auto_b = 1'b0;
        startJob(64'h9000, 32'd64, s);
        applyStimulus();
        applyStimulus();
        checkOutput("rst_pre_istart", 64'(lcl_istart), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_istart", 64'(lcl_istart), 64'd0);
        checkOutput("rst_async_iaddr", lcl_iaddr, 64'd0);
        checkOutput("rst_async_inum", 64'(lcl_inum), 64'd0);
        checkOutput("rst_async_busy", 64'(job_busy), 64'd0);
        checkOutput("rst_async_done", 64'(job_done), 64'd0);
        checkOutput("rst_async_error", 64'(job_error), 64'd0);
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();

        // T7: master busy holds the command back.
        $display("[TB] T7 ibusy gating");
        newTest();
        auto_b    = 1'b1;
        lcl_ibusy = 1'b1;
        startJob(64'h9000, 32'd1, s);
        repeat (5) applyStimulus();
        checkOutput("t7_held_by_ibusy", 64'(ist_addr_q.size()), 64'd0);
        lcl_ibusy = 1'b0;
        waitDone("t7_done_seen", 20);
        checkOutput("t7_burst_count", 64'(ist_addr_q.size()), 64'd1);
        checkBurst("t7_b0", 0, 64'h9000, 8'd1);
        if (ist_cyc_q.size() > 0) begin
            checkOutput("t7_istart_cycle", 64'(ist_cyc_q[0] - s), 64'd6);
        end
        checkOutput("t7_error", 64'(job_error), 64'd0);
        repeat (2) applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
